vga_plot_sink: RTL and testbench

- Receiving end of the plotter pixel-write interface (x, y, colour, writeEn).
- Stores plotted pixels in a 160x120x3-bit on-chip framebuffer.
- Scans the framebuffer out as 640x480@60 VGA, with 4x4 pixel replication, from the 50 MHz system clock.
- Sits between the drawing FSMs and the board DAC/VGA pins.

---
 rtl/vga_plot_sink.sv | 202 ++++++++++++++++++++
 tb/tb_vga_plot_sink.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_sink.sv
// vga_plot_sink: receiving end of the plotter pixel-write port.
// Holds a 160x120x3-bit framebuffer and scans it out as 640x480@60 VGA
// with 4x4 pixel replication, driven from the 50 MHz system clock.
//
// Write port: writeEn is a one-sided strobe with no ready. In RUN, every
// cycle with writeEn=1 and in-range (x,y) stores one pixel and never
// stalls. In CLEAR, all writes are dropped and busy is high.
module vga_plot_sink #(
  parameter int         H_VIS      = 640,
  parameter int         H_FP       = 16,
  parameter int         H_SYNC     = 96,
  parameter int         H_BP       = 48,
  parameter int         V_VIS      = 480,
  parameter int         V_FP       = 10,
  parameter int         V_SYNC     = 2,
  parameter int         V_BP       = 33,
  parameter logic [2:0] BACKGROUND = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       writeEn,
  output logic       busy,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       frame_start
);

  localparam int          FB_DEPTH   = 160 * 120;
  localparam logic [14:0] CLEAR_LAST = 15'(FB_DEPTH - 1);
  localparam logic [7:0]  X_LIMIT    = 8'd160;
  localparam logic [6:0]  Y_LIMIT    = 7'd120;

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [14:0] clear_addr, clear_addr_nxt;

  logic        mem_we;
  logic [14:0] mem_waddr;
  logic [2:0]  mem_wdata;
  logic [14:0] plot_addr;
  logic [14:0] y_ext;
  logic        plot_ok;

  logic [2:0]  fb_mem [0:FB_DEPTH-1];
  logic [2:0]  rd_data;
  logic [14:0] rd_addr;
  logic [14:0] vq_ext;

  logic        pix_en;
  logic [9:0]  h_cnt, v_cnt;
  logic        h_wrap, v_wrap;

  logic        hs_raw, vs_raw, blank_raw;
  logic        hs_d1, vs_d1, blank_d1, run_d1;

  // y*160 + x built from shifts; out-of-range coordinates never write
  assign y_ext     = {8'd0, y};
  assign plot_addr = (y_ext << 7) + (y_ext << 5) + {7'd0, x};
  assign plot_ok   = writeEn && (x < X_LIMIT) && (y < Y_LIMIT);
  assign busy      = (state == CLEAR);

  // Control state register: clear sweep restarts from address 0 after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      clear_addr <= '0;
    end else begin
      state      <= state_nxt;
      clear_addr <= clear_addr_nxt;
    end
  end

  // Next state and write-port selection: clear sweep owns the port in CLEAR
  always_comb begin
    state_nxt      = state;
    clear_addr_nxt = clear_addr;
    mem_we         = 1'b0;
    mem_waddr      = '0;
    mem_wdata      = '0;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clear_addr;
        mem_wdata = BACKGROUND;
        if (clear_addr == CLEAR_LAST) begin
          state_nxt = RUN;
        end else begin
          clear_addr_nxt = clear_addr + 15'd1;
        end
      end
      RUN: begin
        if (plot_ok) begin
          mem_we    = 1'b1;
          mem_waddr = plot_addr;
          mem_wdata = colour;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Framebuffer write port; contents are initialised by the clear sweep
  always_ff @(posedge clk) begin
    if (mem_we) begin
      fb_mem[mem_waddr] <= mem_wdata;
    end
  end

  // Framebuffer read port; a same-cycle write to this address is not seen
  always_ff @(posedge clk) begin
    rd_data <= fb_mem[rd_addr];
  end

  // Pixel enable and raster counters; frame_start marks the (0,0) wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_en      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      frame_start <= pix_en && h_wrap && v_wrap;
      if (pix_en) begin
        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  assign vga_clk = pix_en;
  assign h_wrap  = (h_cnt == H_LAST);
  assign v_wrap  = (v_cnt == V_LAST);

  // Replicated read address: (v/4)*160 + h/4
  assign vq_ext  = {7'd0, v_cnt[9:2]};
  assign rd_addr = (vq_ext << 7) + (vq_ext << 5) + {7'd0, h_cnt[9:2]};

  assign hs_raw    = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw    = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign blank_raw = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);

  // First delay stage: timing flags travel alongside the memory read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
      blank_d1 <= 1'b0;
      run_d1   <= 1'b0;
    end else begin
      hs_d1    <= hs_raw;
      vs_d1    <= vs_raw;
      blank_d1 <= blank_raw;
      run_d1   <= (state == RUN);
    end
  end

  // Output stage: colour expanded to 8 bits, black when blanked or clearing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
    end else begin
      vga_hs      <= hs_d1;
      vga_vs      <= vs_d1;
      vga_blank_n <= blank_d1;
      vga_r       <= (blank_d1 && run_d1 && rd_data[2]) ? 8'hFF : 8'h00;
      vga_g       <= (blank_d1 && run_d1 && rd_data[1]) ? 8'hFF : 8'h00;
      vga_b       <= (blank_d1 && run_d1 && rd_data[0]) ? 8'hFF : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_plot_sink.sv
// tb_vga_plot_sink: directed bench for vga_plot_sink.
// Main instance uses 640x480 timing; a second instance with a 22-line
// frame lets vsync and frame_start be observed within a short run.
module tb_vga_plot_sink;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       writeEn = 1'b0;

  logic       busy, vga_clk, vga_hs, vga_vs, vga_blank_n, frame_start;
  logic [7:0] vga_r, vga_g, vga_b;

  logic       s_busy, s_vga_clk, s_vga_hs, s_vga_vs, s_vga_blank_n, s_frame_start;
  logic [7:0] s_vga_r, s_vga_g, s_vga_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [2:0] gold [0:19199];

  // Directed plot writes and whether each one must land
  logic [7:0] wx  [8] = '{8'd5, 8'd160, 8'd0, 8'd160, 8'd255, 8'd10, 8'd10, 8'd159};
  logic [6:0] wy  [8] = '{7'd3, 7'd0, 7'd120, 7'd4, 7'd3, 7'd4, 7'd4, 7'd5};
  logic [2:0] wc  [8] = '{3'b101, 3'b111, 3'b111, 3'b111, 3'b111, 3'b010, 3'b011, 3'b110};
  bit         whit[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  vga_plot_sink u_dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
    .busy(busy), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  vga_plot_sink #(.V_VIS(16), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_small (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
    .busy(s_busy), .vga_clk(s_vga_clk), .vga_hs(s_vga_hs), .vga_vs(s_vga_vs),
    .vga_blank_n(s_vga_blank_n), .vga_r(s_vga_r), .vga_g(s_vga_g), .vga_b(s_vga_b),
    .frame_start(s_frame_start)
  );

  // Clock and cycle count since reset release
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Golden output at cycle k: {frame_start, hs, vs, blank_n, r, g, b}
  function automatic logic [27:0] model_out(int k, int vt, int vvis, int vs0, bit with_rgb);
    int c, h, v;
    logic fs, hs, vs, bl;
    logic [2:0] col;
    fs = (k > 0) && ((k % (1600 * vt)) == 0);
    hs = 1'b1; vs = 1'b1; bl = 1'b0; col = 3'b000;
    if (k >= 2) begin
      c  = k - 2;
      h  = (c / 2) % 800;
      v  = (c / 1600) % vt;
      hs = !((h >= 656) && (h < 752));
      vs = !((v >= vs0) && (v < vs0 + 2));
      bl = (h < 640) && (v < vvis);
      if (bl && with_rgb && (k >= 19202)) col = gold[(v / 4) * 160 + h / 4];
    end
    return {fs, hs, vs, bl, {8{col[2]}}, {8{col[1]}}, {8{col[0]}}};
  endfunction

  task automatic clear_gold();
    for (int i = 0; i < 19200; i++) gold[i] = 3'b000;
  endtask

  task automatic test_reset();
    logic [29:0] exp_v;
    reset = 1'b1; writeEn = 1'b0;
    repeat (3) @(negedge clk);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    checks++;
    if ({busy, vga_clk, frame_start, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b} !== exp_v) begin
      failures++;
      $display("FAIL reset_main got=%h exp=%h",
               {busy, vga_clk, frame_start, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b}, exp_v);
    end
    checks++;
    if ({s_busy, s_vga_clk, s_frame_start, s_vga_hs, s_vga_vs, s_vga_blank_n} !== exp_v[29:24]) begin
      failures++;
      $display("FAIL reset_small got=%b exp=%b",
               {s_busy, s_vga_clk, s_frame_start, s_vga_hs, s_vga_vs, s_vga_blank_n}, exp_v[29:24]);
    end
    clear_gold();
    reset = 1'b0;
  endtask

  // Counts busy cycles after release; optionally plots during the clear
  task automatic test_clear(input bit drop_write);
    while (busy === 1'b1 && cyc < 25000) begin
      if (drop_write && cyc == 100) begin
        writeEn = 1'b1; x = 8'd1; y = 7'd4; colour = 3'b111;
      end else begin
        writeEn = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({vga_r, vga_g, vga_b} !== 24'h000000) begin
        failures++;
        $display("FAIL clear_rgb cyc=%0d got=%h exp=000000", cyc, {vga_r, vga_g, vga_b});
      end
    end
    writeEn = 1'b0;
    checks++;
    if (cyc !== 19200 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_len got=%0d busy=%b exp=19200 busy=0", cyc, busy);
    end
  endtask

  task automatic test_plot();
    for (int i = 0; i < 8; i++) begin
      writeEn = 1'b1; x = wx[i]; y = wy[i]; colour = wc[i];
      if (whit[i]) gold[int'(wy[i]) * 160 + int'(wx[i])] = wc[i];
      @(negedge clk);
    end
    writeEn = 1'b0;
  endtask

  // Hand-computed spot checks around cell (5,3) on line v=12
  task automatic test_pixel();
    int k_at[3]      = '{19240, 19242, 19250};
    logic [23:0] e[3] = '{24'h000000, 24'hFF00FF, 24'h000000};
    for (int i = 0; i < 3; i++) begin
      while (cyc < k_at[i]) @(negedge clk);
      checks++;
      if ({vga_r, vga_g, vga_b} !== e[i]) begin
        failures++;
        $display("FAIL pixel_5_3 cyc=%0d got=%h exp=%h", cyc, {vga_r, vga_g, vga_b}, e[i]);
      end
    end
  endtask

  task automatic test_scan(input int end_cyc);
    logic [27:0] exp_m, exp_s, got_m, got_s;
    while (cyc < end_cyc) begin
      @(negedge clk);
      exp_m = model_out(cyc, 525, 480, 490, 1'b1);
      got_m = {frame_start, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b};
      checks++;
      if (got_m !== exp_m) begin
        failures++;
        $display("FAIL scan_main cyc=%0d got=%h exp=%h", cyc, got_m, exp_m);
      end
      exp_s = model_out(cyc, 22, 16, 18, 1'b0);
      got_s = {s_frame_start, s_vga_hs, s_vga_vs, s_vga_blank_n, 24'h000000};
      checks++;
      if (got_s[27:24] !== exp_s[27:24]) begin
        failures++;
        $display("FAIL scan_small cyc=%0d got=%b exp=%b", cyc, got_s[27:24], exp_s[27:24]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [29:0] exp_v;
    #2 reset = 1'b1;
    #1;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    checks++;
    if ({busy, vga_clk, frame_start, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b} !== exp_v) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h",
               {busy, vga_clk, frame_start, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b}, exp_v);
    end
    repeat (2) @(negedge clk);
    clear_gold();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clear(1'b1);
    test_plot();
    test_pixel();
    test_scan(36000);
    test_async_reset();
    while (cyc < 5000) @(negedge clk);
    test_async_reset();
    test_clear(1'b0);
    test_scan(22400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
